// File: rtl/word_banner_pkg.sv
// Shared types and constants for the centre-screen banner sequencer.
// Optional build macro: WORD_BANNER_BLINK_EN (blinking result banners).
package word_banner_pkg;

  // Round state; the numeric values are visible on the debug/HUD port.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FIGHT = 3'd1,
    ST_PLAY  = 3'd2,
    ST_WIN   = 3'd3,
    ST_LOSE  = 3'd4
  } state_e;

  // Frame counters are 8 bits wide; all frame limits must fit in 1..255.
  localparam int CNT_W = 8;

  localparam int DEFAULT_FIGHT_FRAMES  = 120;
  localparam int DEFAULT_RESULT_FRAMES = 90;
  localparam int DEFAULT_BLINK_FRAMES  = 30;

  // True for the states that show a result banner.
  function automatic logic is_result_state(input state_e s);
    return (s == ST_WIN) || (s == ST_LOSE);
  endfunction

endpackage

// File: rtl/frame_counter.sv
// 8-bit frame counter: synchronous clear, counts ticks, saturates at limit_i.
// hit_o is high while count_o equals limit_i.
module frame_counter
  import word_banner_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             tick_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic [CNT_W-1:0] count_o,
  output logic             hit_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Clear wins over counting; counting stops once the limit is reached.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (tick_i && (count_q != limit_i)) begin
      count_d = count_q + 8'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign hit_o   = (count_q == limit_i);

endmodule

// File: rtl/word_banner_sequencer.sv
// Round banner sequencer: IDLE -> FIGHT -> PLAY -> WIN/LOSE -> IDLE.
// Drives the FIGHT!/VICTORY!/DEFEAT! word overlays (at most one at a time)
// and gates fighter control. All outputs are registered from the next state.
// Optional build macro: WORD_BANNER_BLINK_EN makes result banners blink.
module word_banner_sequencer
  import word_banner_pkg::*;
#(
  parameter int FIGHT_FRAMES  = DEFAULT_FIGHT_FRAMES,
  parameter int RESULT_FRAMES = DEFAULT_RESULT_FRAMES,
  parameter int BLINK_FRAMES  = DEFAULT_BLINK_FRAMES
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_tick,
  input  logic       round_start,
  input  logic       restart,
  input  logic       player_ko,
  input  logic       npc_ko,
  output logic       fight_active,
  output logic       victory_active,
  output logic       defeat_active,
  output logic       play_enable,
  output logic [2:0] state_o
);

  // Frame limits outside 1..255 cannot be represented by the 8-bit counters.
  if (FIGHT_FRAMES < 1 || FIGHT_FRAMES > 255) begin : g_bad_fight
    $error("FIGHT_FRAMES must be in 1..255");
  end
  if (RESULT_FRAMES < 1 || RESULT_FRAMES > 255) begin : g_bad_result
    $error("RESULT_FRAMES must be in 1..255");
  end
  if (BLINK_FRAMES < 1 || BLINK_FRAMES > 255) begin : g_bad_blink
    $error("BLINK_FRAMES must be in 1..255");
  end

  localparam logic [CNT_W-1:0] FIGHT_LIM  = CNT_W'(FIGHT_FRAMES);
  localparam logic [CNT_W-1:0] RESULT_LIM = CNT_W'(RESULT_FRAMES);

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] cnt_count;
  logic             cnt_hit;
  logic             cnt_clr;
  logic [CNT_W-1:0] cnt_limit;
  logic             fight_done;
  logic             banner_vis;

  logic fight_q;
  logic victory_q;
  logic defeat_q;
  logic play_q;

  // The tick that would bring the FIGHT count up to its limit ends FIGHT.
  assign fight_done = frame_tick && (cnt_count == (FIGHT_LIM - 8'd1));

  // Next-state logic; KO inputs only matter in PLAY, a double KO is a defeat.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (round_start) state_d = ST_FIGHT;
      ST_FIGHT: if (fight_done) state_d = ST_PLAY;
      ST_PLAY: begin
        if (player_ko) begin
          state_d = ST_LOSE;
        end else if (npc_ko) begin
          state_d = ST_WIN;
        end
      end
      ST_WIN, ST_LOSE: if (restart && cnt_hit) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Counter restarts on every transition so a coincident tick is not
  // carried into the new state; it only runs in FIGHT and the result states.
  always_comb begin
    cnt_clr   = (state_d != state_q) || (state_q == ST_IDLE) || (state_q == ST_PLAY);
    cnt_limit = (state_q == ST_FIGHT) ? FIGHT_LIM : RESULT_LIM;
  end

  frame_counter u_state_cnt (
    .clk_i   (Clk),
    .rst_ni  (Reset_n),
    .clr_i   (cnt_clr),
    .tick_i  (frame_tick),
    .limit_i (cnt_limit),
    .count_o (cnt_count),
    .hit_o   (cnt_hit)
  );

`ifdef WORD_BANNER_BLINK_EN
  localparam logic [CNT_W-1:0] BLINK_LIM = CNT_W'(BLINK_FRAMES);

  logic [CNT_W-1:0] blink_count;
  logic             blink_hit;
  logic             blink_clr;
  logic             blink_wrap;
  logic             result_entry;
  logic             phase_q;
  logic             phase_d;

  // Phase flips every BLINK_FRAMES ticks in a result state; forced visible on entry.
  always_comb begin
    result_entry = is_result_state(state_d) && !is_result_state(state_q);
    blink_wrap   = is_result_state(state_q) && frame_tick &&
                   ((blink_count == (BLINK_LIM - 8'd1)) || blink_hit);
    blink_clr    = !is_result_state(state_q) || (state_d != state_q) || blink_wrap;
    phase_d      = phase_q;
    if (result_entry) begin
      phase_d = 1'b1;
    end else if (blink_wrap) begin
      phase_d = ~phase_q;
    end
    banner_vis = phase_d;
  end

  // Blink phase register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      phase_q <= 1'b1;
    end else begin
      phase_q <= phase_d;
    end
  end

  frame_counter u_blink_cnt (
    .clk_i   (Clk),
    .rst_ni  (Reset_n),
    .clr_i   (blink_clr),
    .tick_i  (frame_tick),
    .limit_i (BLINK_LIM),
    .count_o (blink_count),
    .hit_o   (blink_hit)
  );
`else
  // Result banners are steady.
  assign banner_vis = 1'b1;
`endif

  // Moore outputs decoded from the next state so they move with the state.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fight_q   <= 1'b0;
      victory_q <= 1'b0;
      defeat_q  <= 1'b0;
      play_q    <= 1'b0;
    end else begin
      fight_q   <= (state_d == ST_FIGHT);
      victory_q <= (state_d == ST_WIN) && banner_vis;
      defeat_q  <= (state_d == ST_LOSE) && banner_vis;
      play_q    <= (state_d == ST_PLAY);
    end
  end

  assign fight_active   = fight_q;
  assign victory_active = victory_q;
  assign defeat_active  = defeat_q;
  assign play_enable    = play_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_word_banner_sequencer.sv
// Self-checking bench for word_banner_sequencer (FIGHT=4, RESULT=3, BLINK=2).
// Expected outputs come from a frame-level round model kept in this file.
// Honours WORD_BANNER_BLINK_EN for the expected result-banner visibility.
module tb_word_banner_sequencer;

  localparam int F = 4;
  localparam int R = 3;
  localparam int B = 2;

  localparam int M_IDLE  = 0;
  localparam int M_FIGHT = 1;
  localparam int M_PLAY  = 2;
  localparam int M_WIN   = 3;
  localparam int M_LOSE  = 4;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       frame_tick;
  logic       round_start;
  logic       restart;
  logic       player_ko;
  logic       npc_ko;
  logic       fight_active;
  logic       victory_active;
  logic       defeat_active;
  logic       play_enable;
  logic [2:0] state_o;

  int checks;
  int errors;

  // round model
  int m_mode;
  int m_ticks;
  int m_blink_ticks;
  bit m_vis;

  // clock / reset block
  always #5 Clk = ~Clk;

  word_banner_sequencer #(
    .FIGHT_FRAMES  (F),
    .RESULT_FRAMES (R),
    .BLINK_FRAMES  (B)
  ) dut (
    .Clk            (Clk),
    .Reset_n        (Reset_n),
    .frame_tick     (frame_tick),
    .round_start    (round_start),
    .restart        (restart),
    .player_ko      (player_ko),
    .npc_ko         (npc_ko),
    .fight_active   (fight_active),
    .victory_active (victory_active),
    .defeat_active  (defeat_active),
    .play_enable    (play_enable),
    .state_o        (state_o)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode        = M_IDLE;
    m_ticks       = 0;
    m_blink_ticks = 0;
    m_vis         = 1'b1;
  endtask

  function automatic bit exp_vis();
`ifdef WORD_BANNER_BLINK_EN
    return m_vis;
`else
    return 1'b1;
`endif
  endfunction

  // Advance the model by one clock with the given inputs.
  task automatic model_step(input bit rs, input bit rst, input bit pko, input bit nko, input bit tk);
    if (m_mode == M_IDLE) begin
      if (rs) begin
        m_mode  = M_FIGHT;
        m_ticks = 0;
      end
    end else if (m_mode == M_FIGHT) begin
      if (tk) begin
        m_ticks++;
        if (m_ticks == F) begin
          m_mode  = M_PLAY;
          m_ticks = 0;
        end
      end
    end else if (m_mode == M_PLAY) begin
      if (pko || nko) begin
        m_mode        = pko ? M_LOSE : M_WIN;
        m_ticks       = 0;
        m_blink_ticks = 0;
        m_vis         = 1'b1;
      end
    end else begin
      if (rst && m_ticks == R) begin
        m_mode  = M_IDLE;
        m_ticks = 0;
      end else if (tk) begin
        if (m_ticks < R) m_ticks++;
        m_blink_ticks++;
        if (m_blink_ticks == B) begin
          m_vis         = !m_vis;
          m_blink_ticks = 0;
        end
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    int n;
    check({tag, ".state"},   8'(state_o),        8'(m_mode));
    check({tag, ".fight"},   8'(fight_active),   8'(m_mode == M_FIGHT));
    check({tag, ".play"},    8'(play_enable),    8'(m_mode == M_PLAY));
    check({tag, ".victory"}, 8'(victory_active), 8'((m_mode == M_WIN) && exp_vis()));
    check({tag, ".defeat"},  8'(defeat_active),  8'((m_mode == M_LOSE) && exp_vis()));
    n = int'(fight_active) + int'(victory_active) + int'(defeat_active) + int'(play_enable);
    check({tag, ".onehot"},  8'(n <= 1),         8'd1);
  endtask

  // driver: called at a falling edge, drives inputs for the next rising edge
  task automatic cycle(input bit rs, input bit rst, input bit pko, input bit nko,
                       input bit tk, input string tag);
    round_start = rs;
    restart     = rst;
    player_ko   = pko;
    npc_ko      = nko;
    frame_tick  = tk;
    model_step(rs, rst, pko, nko, tk);
    @(negedge Clk);
    check_outputs(tag);
  endtask

  // n frames of 10 clocks each, the tick on the last clock
  task automatic run_frames(input int n, input bit rst, input bit pko, input bit nko,
                            input string tag);
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < 9; j++) cycle(1'b0, rst, pko, nko, 1'b0, tag);
      cycle(1'b0, rst, pko, nko, 1'b1, tag);
    end
  endtask

  // Asynchronous reset pulse between clock edges.
  task automatic async_reset(input string tag);
    round_start = 1'b0;
    restart     = 1'b0;
    player_ko   = 1'b0;
    npc_ko      = 1'b0;
    frame_tick  = 1'b0;
    #2 Reset_n = 1'b0;
    #1 model_reset();
    check_outputs({tag, ".async"});
    @(negedge Clk);
    check_outputs({tag, ".held"});
    Reset_n = 1'b1;
  endtask

  initial begin
    bit pat[6];
    checks = 0;
    errors = 0;
`ifdef WORD_BANNER_BLINK_EN
    pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
`else
    pat = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`endif
    Reset_n     = 1'b0;
    round_start = 1'b0;
    restart     = 1'b0;
    player_ko   = 1'b0;
    npc_ko      = 1'b0;
    frame_tick  = 1'b0;
    model_reset();
    repeat (2) @(negedge Clk);
    check_outputs("reset");
    Reset_n = 1'b1;

    // IDLE ignores KO and ticks
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, "idle_ko");
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "idle");

    // round start: FIGHT for exactly 4 ticks
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "start");
    check("start_fight", 8'(fight_active), 8'd1);
    run_frames(3, 1'b0, 1'b1, 1'b1, "fight_ko_ignored");
    check("fight_after_3", 8'(fight_active), 8'd1);
    run_frames(1, 1'b0, 1'b0, 1'b0, "fight_end");
    check("play_state", 8'(state_o), 8'd2);
    check("play_en", 8'(play_enable), 8'd1);
    check("fight_off", 8'(fight_active), 8'd0);

    // npc KO -> WIN, early restart dropped, late restart honoured
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "npc_ko");
    check("win_victory", 8'(victory_active), 8'd1);
    check("win_play_off", 8'(play_enable), 8'd0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "win_early_restart");
    run_frames(2, 1'b1, 1'b0, 1'b0, "win_hold");
    check("win_held", 8'(state_o), 8'd3);
    run_frames(1, 1'b1, 1'b0, 1'b0, "win_third");
    check("win_third_state", 8'(state_o), 8'd3);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "win_restart");
    check("restart_idle", 8'(state_o), 8'd0);
    check("restart_victory_off", 8'(victory_active), 8'd0);

    // double KO is a defeat
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "start2");
    run_frames(4, 1'b0, 1'b0, 1'b0, "fight2");
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "double_ko");
    check("dko_defeat", 8'(defeat_active), 8'd1);
    check("dko_victory", 8'(victory_active), 8'd0);
    run_frames(3, 1'b0, 1'b0, 1'b0, "lose_hold");
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "lose_restart");

    // reset mid-FIGHT, then a start coincident with a tick
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "start3");
    run_frames(2, 1'b0, 1'b0, 1'b0, "fight3");
    async_reset("mid_fight");
    check("rst_fight_off", 8'(fight_active), 8'd0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "start_tick");
    run_frames(3, 1'b0, 1'b0, 1'b0, "fight4");
    check("fight4_still", 8'(fight_active), 8'd1);
    run_frames(1, 1'b0, 1'b0, 1'b0, "fight4_end");
    check("fight4_play", 8'(play_enable), 8'd1);

    // result banner visibility per tick
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "blink_entry");
    check("blink0", 8'(victory_active), 8'(pat[0]));
    for (int i = 1; i < 6; i++) begin
      run_frames(1, 1'b0, 1'b0, 1'b0, "blink_run");
      check($sformatf("blink%0d", i), 8'(victory_active), 8'(pat[i]));
    end
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "blink_restart");

    // randomized rounds
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 499) == 0) begin
        async_reset("rand");
      end else begin
        cycle($urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0,
              $urandom_range(0, 15) == 0, $urandom_range(0, 9) == 0,
              $urandom_range(0, 3) == 0, "rand");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
